// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multi-digit hex 7-segment driver with load, free-running count, blink and leading-zero blanking
//   clk, rst_n       : clock, asynchronous active-low reset
//   data, load       : value to latch and its one-cycle strobe
//   mode             : 0 static, 1 up-counter advancing every TICK_DIV cycles
//   blink_en         : blank whole display on alternate BLINK_DIV-cycle phases
//   lz_blank         : blank digits above the most significant nonzero digit
//   value            : displayed value register
//   seg              : registered active-low segments, {g,f,e,d,c,b,a} per digit
module seg_display_ctrl #(
  parameter int DIGITS    = 2,
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  blink_en,
  input  logic                  lz_blank,
  output logic [4*DIGITS-1:0]   value,
  output logic [7*DIGITS-1:0]   seg
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [PW-1:0]       pre_q, pre_d;
  logic [BW-1:0]       blk_q, blk_d;
  logic                on_q, on_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic                tick, blk_wrap, show, zero_above;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction
  always_comb begin
    tick = mode && (pre_q == PW'(TICK_DIV - 1));
    value_d = load ? data : tick ? value_q + 1'b1 : value_q;
    pre_d = (load || !mode || tick) ? '0 : pre_q + 1'b1;
    blk_wrap = blk_q == BW'(BLINK_DIV - 1);
    blk_d = (!blink_en || blk_wrap) ? '0 : blk_q + 1'b1;
    on_d = !blink_en || (on_q ^ blk_wrap);
    // dropping blink_en shows digits on the same edge it is sampled, like lz_blank
    show = on_q || !blink_en;
    zero_above = 1'b1;
    seg_d = '1;
    // walk from the top digit down; zero_above stays set while every digit so far is zero
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (value_q[4*i +: 4] == 4'h0);
      seg_d[7*i +: 7] = (!show || (lz_blank && zero_above && i != 0)) ? 7'h7F : hex7(value_q[4*i +: 4]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      pre_q   <= '0;
      blk_q   <= '0;
      on_q    <= 1'b1;
      seg_q   <= '1;
    end else begin
      value_q <= value_d;
      pre_q   <= pre_d;
      blk_q   <= blk_d;
      on_q    <= on_d;
      seg_q   <= seg_d;
    end
  end
  assign value = value_q;
  assign seg   = seg_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed self-checking bench for seg_display_ctrl (DIGITS=2, TICK_DIV=4, BLINK_DIV=3)
module tb_seg_display_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  data = '0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic        blink_en = 1'b0;
  logic        lz_blank = 1'b0;
  logic [7:0]  value;
  logic [13:0] seg;
  int          n_checks = 0;
  int          n_fail = 0;
  seg_display_ctrl #(.DIGITS(2), .TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .mode(mode),
    .blink_en(blink_en), .lz_blank(lz_blank), .value(value), .seg(seg)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg_async", seg, 14'h3FFF);
    chk("rst_value_async", value, 8'h00);
    step(2);
    rst_n = 1'b1;
    chk("rst_hold_seg", seg, 14'h3FFF);
    step();
    chk("post_rst_seg_00", seg, 14'h2040);
    lz_blank = 1'b1;
    step();
    chk("lz_zero", seg, 14'h3FC0);
    lz_blank = 1'b0;
    data = 8'hA5;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("load_a5_value", value, 8'hA5);
    step();
    chk("seg_a5", seg, 14'h0412);
    step(3);
    chk("hold_a5_value", value, 8'hA5);
    chk("hold_a5_seg", seg, 14'h0412);
    data = 8'hFE;
    load = 1'b1;
    step();
    load = 1'b0;
    mode = 1'b1;
    chk("load_fe", value, 8'hFE);
    step(3);
    chk("count_fe_pre", value, 8'hFE);
    step();
    chk("count_ff", value, 8'hFF);
    step(4);
    chk("count_wrap_00", value, 8'h00);
    step(4);
    chk("count_01", value, 8'h01);
    chk("seg_lag_00", seg, 14'h2040);
    step();
    chk("seg_01", seg, 14'h2079);
    step(2);
    data = 8'h30;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("load_beats_tick", value, 8'h30);
    step(3);
    chk("after_load_hold", value, 8'h30);
    step();
    chk("after_load_tick", value, 8'h31);
    step(2);
    mode = 1'b0;
    step();
    chk("freeze_31", value, 8'h31);
    step(3);
    chk("frozen_31", value, 8'h31);
    mode = 1'b1;
    step(3);
    chk("restart_pre_hold", value, 8'h31);
    step();
    chk("restart_tick_32", value, 8'h32);
    mode = 1'b0;
    data = 8'h88;
    load = 1'b1;
    step();
    load = 1'b0;
    blink_en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      chk($sformatf("blink_c%0d", c), seg, ((c / 3) % 2 == 1) ? 14'h3FFF : 14'h0000);
    end
    step();
    chk("blink_off_again", seg, 14'h3FFF);
    blink_en = 1'b0;
    step();
    chk("blink_disable", seg, 14'h0000);
    lz_blank = 1'b1;
    data = 8'h05;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("lz_05", seg, 14'h3F92);
    data = 8'h50;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("lz_50", seg, 14'h0940);
    mode = 1'b1;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("midcount_rst_value", value, 8'h00);
    chk("midcount_rst_seg", seg, 14'h3FFF);
    #1 rst_n = 1'b1;
    data = 8'h77;
    load = 1'b1;
    step();
    load = 1'b0;
    mode = 1'b0;
    chk("first_edge_load", value, 8'h77);
    chk("first_edge_seg", seg, 14'h3FC0);
    step();
    chk("seg_77", seg, 14'h3C78);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
